// File: rtl/r2fft_bfly_sequencer.sv
// Radix-2 in-place FFT butterfly sequencer: per-stage address/twiddle issue and token delay.
// Optional cycle counter output enabled by R2FFT_SEQ_CYCLE_COUNT_EN.
module r2fft_bfly_sequencer #(
    parameter int  FFT_N      = 10,
    parameter int  MEM_RD_LAT = 1,
    parameter int  STAGE_GAP  = 4,
    localparam int SW         = (FFT_N > 1) ? $clog2(FFT_N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             rdEn,
    output logic [FFT_N-1:0] rdAddrA,
    output logic [FFT_N-1:0] rdAddrB,
    output logic [FFT_N-2:0] twAddr,
    output logic [SW-1:0]    stage,
    output logic             oact,
    output logic [1:0]       octrl,
`ifdef R2FFT_SEQ_CYCLE_COUNT_EN
    output logic [31:0]      cycleCount,
`endif
    output logic [FFT_N-2:0] oMemAddr
);

    localparam int GW = $clog2(STAGE_GAP + 2);
    localparam int TW = FFT_N + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [FFT_N-2:0] j_q, j_d, run_j;
    logic [SW-1:0]    s_q, s_d, run_s;
    logic [GW-1:0]    gap_q, gap_d;
    logic             issue, j_last, run_s_last;

    logic [FFT_N-2:0] lo_mask, j_lo, j_hi, tw_v;
    logic [FFT_N-1:0] addr_a, addr_b;

    logic             rd_en_q, rd_en_d;
    logic [FFT_N-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [FFT_N-2:0] tw_q, tw_d;
    logic [SW-1:0]    stage_q, stage_d;

    logic [TW-1:0]    tok_d;
    logic [TW-1:0]    tok_q [MEM_RD_LAT+1];

    // An accepted start issues (0,0) on the same edge, so IDLE behaves as RUN then.
    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        s_d        = s_q;
        gap_d      = gap_q;
        issue      = 1'b0;
        run_s      = (state_q == ST_RUN) ? s_q : '0;
        run_j      = (state_q == ST_RUN) ? j_q : '0;
        run_s_last = (run_s == SW'(FFT_N - 1));
        j_last     = (run_j == '1);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    j_d     = '0;
                    issue   = !hold;
                end
            end
            ST_RUN: issue = !hold;
            ST_GAP: begin
                gap_d = gap_q + 1'b1;
                // Final stage waits one extra cycle so done lines up with the registered issue outputs.
                if (s_q == SW'(FFT_N - 1)) begin
                    if (gap_q == GW'(STAGE_GAP)) state_d = ST_DONE;
                end else if (gap_q == GW'(STAGE_GAP - 1)) begin
                    state_d = ST_RUN;
                    s_d     = s_q + 1'b1;
                    j_d     = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (issue) begin
            j_d = run_j + 1'b1;
            if (j_last) begin
                if (run_s_last || STAGE_GAP != 0) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end else begin
                    s_d = run_s + 1'b1;
                end
            end
        end
    end

    // Insert a zero at bit s of j to form the A/B pair; twiddle stride shrinks per stage.
    always_comb begin
        lo_mask = ~({(FFT_N-1){1'b1}} << run_s);
        j_lo    = run_j & lo_mask;
        j_hi    = run_j & ~lo_mask;
        addr_a  = {j_hi, 1'b0} | {1'b0, j_lo};
        addr_b  = addr_a | (FFT_N'(1) << run_s);
        tw_v    = j_lo << (SW'(FFT_N - 1) - run_s);
        tok_d   = issue ? {1'b1, run_s_last && j_last, run_j == '0, run_j} : '0;
    end

    always_comb begin
        rd_en_d  = issue;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        tw_d     = tw_q;
        stage_d  = stage_q;
        if (issue) begin
            addr_a_d = addr_a;
            addr_b_d = addr_b;
            tw_d     = tw_v;
            stage_d  = run_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            j_q      <= '0;
            s_q      <= '0;
            gap_q    <= '0;
            rd_en_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
            stage_q  <= '0;
            for (int i = 0; i <= MEM_RD_LAT; i++) tok_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            s_q      <= s_d;
            gap_q    <= gap_d;
            rd_en_q  <= rd_en_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
            stage_q  <= stage_d;
            tok_q[0] <= tok_d;
            for (int i = 1; i <= MEM_RD_LAT; i++) tok_q[i] <= tok_q[i-1];
        end
    end

    assign busy    = (state_q == ST_RUN) || (state_q == ST_GAP);
    assign done    = (state_q == ST_DONE);
    assign rdEn    = rd_en_q;
    assign rdAddrA = addr_a_q;
    assign rdAddrB = addr_b_q;
    assign twAddr  = tw_q;
    assign stage   = stage_q;
    assign {oact, octrl, oMemAddr} = tok_q[MEM_RD_LAT];

`ifdef R2FFT_SEQ_CYCLE_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE && start) cnt_d = '0;
        else if (busy)                   cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cycleCount = cnt_q;
`endif

endmodule
